// File: rtl/calculadora_param.sv
// calculadora_param: parametrised unsigned arithmetic unit.
// It provides single-cycle add, subtract, accumulate, max, min and
// accumulator-clear operations. Multiplication is a multi-cycle shift-add
// that runs for WIDTH steps.
// Optional build macro CALC_SATURATE_EN: when defined, overflowing results
// clamp to all ones and borrows clamp to zero. When it is undefined, results
// wrap modulo 2^WIDTH. The overflow flag behaves the same in both builds.
module calculadora_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [2:0]       modo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

`ifdef CALC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] M_SUMA  = 3'b000;
  localparam logic [2:0] M_RESTA = 3'b001;
  localparam logic [2:0] M_MUL   = 3'b010;
  localparam logic [2:0] M_ACUM  = 3'b011;
  localparam logic [2:0] M_MAX   = 3'b100;
  localparam logic [2:0] M_MIN   = 3'b101;
  localparam logic [2:0] M_CLR   = 3'b110;
  localparam logic [2:0] M_RSV   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand, prod;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     acc;

  logic                 start_mul, do_single, mul_step, mul_done;

  logic [WIDTH:0]       sum, diff, accsum;
  logic [WIDTH-1:0]     res_c, res_acc;
  logic                 res_ovf, res_acc_we, res_valid;
  logic                 prod_ovf;

  // Clamp high on carry-out when saturation is built in, else pass the wrapped value
  function automatic logic [WIDTH-1:0] sat_hi(input logic [WIDTH-1:0] wrapped,
                                              input logic             ovf);
    return (SAT_EN && ovf) ? {WIDTH{1'b1}} : wrapped;
  endfunction

  // Clamp to zero on borrow when saturation is built in
  function automatic logic [WIDTH-1:0] sat_lo(input logic [WIDTH-1:0] wrapped,
                                              input logic             brw);
    return (SAT_EN && brw) ? {WIDTH{1'b0}} : wrapped;
  endfunction

  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign accsum   = {1'b0, acc} + {1'b0, a};
  assign prod_ovf = |prod[2*WIDTH-1:WIDTH];
  assign busy     = (state != IDLE);

  // Result of the single-cycle modes for the operands currently presented
  always_comb begin
    res_c      = '0;
    res_ovf    = 1'b0;
    res_acc    = acc;
    res_acc_we = 1'b0;
    res_valid  = 1'b1;
    case (modo)
      M_SUMA: begin
        res_ovf = sum[WIDTH];
        res_c   = sat_hi(sum[WIDTH-1:0], sum[WIDTH]);
      end
      M_RESTA: begin
        res_ovf = diff[WIDTH];
        res_c   = sat_lo(diff[WIDTH-1:0], diff[WIDTH]);
      end
      M_ACUM: begin
        res_ovf    = accsum[WIDTH];
        res_acc    = sat_hi(accsum[WIDTH-1:0], accsum[WIDTH]);
        res_acc_we = 1'b1;
        res_c      = sat_hi(accsum[WIDTH-1:0], accsum[WIDTH]);
      end
      M_MAX:   res_c = (a > b) ? a : b;
      M_MIN:   res_c = (a < b) ? a : b;
      M_CLR: begin
        res_acc    = '0;
        res_acc_we = 1'b1;
      end
      M_MUL:   res_valid = 1'b0;
      M_RSV:   res_valid = 1'b0;
      default: res_valid = 1'b0;
    endcase
  end

  // Control sequencing: requests are taken only in IDLE; multiply walks MUL then DONE
  always_comb begin
    state_nxt = state;
    start_mul = 1'b0;
    do_single = 1'b0;
    mul_step  = 1'b0;
    mul_done  = 1'b0;
    case (state)
      IDLE: begin
        if (enb) begin
          if (modo == M_MUL) begin
            start_mul = 1'b1;
            state_nxt = MUL;
          end else begin
            do_single = res_valid;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        mul_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any multiplication in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shift-add multiplier: operands latched at start, one partial product per cycle
  always_ff @(posedge clk) begin
    if (start_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
    end else if (mul_step) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result, status and accumulator registers; valid pulses only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      c        <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      acc      <= '0;
    end else begin
      valid <= 1'b0;
      if (do_single) begin
        c        <= res_c;
        overflow <= res_ovf;
        valid    <= 1'b1;
        if (res_acc_we) acc <= res_acc;
      end else if (mul_done) begin
        c        <= sat_hi(prod[WIDTH-1:0], prod_ovf);
        overflow <= prod_ovf;
        valid    <= 1'b1;
      end
    end
  end

endmodule
